// File: rtl/ri_exec_pipe_if.sv
// Bus bundle for ri_exec_pipe: instruction handshake, writeback, counters,
// debug register read and condition register.
interface ri_exec_pipe_if #(
    parameter int unsigned N = 64
);
    logic [31:0]  instruction;
    logic         in_valid;
    logic         in_ready;
    logic         hold;
    logic         wb_valid;
    logic [4:0]   wb_reg;
    logic [N-1:0] wb_data;
    logic         illegal;
    logic [31:0]  retired_cnt;
    logic [15:0]  illegal_cnt;
    logic [4:0]   dbg_addr;
    logic [N-1:0] dbg_data;
    logic [2:0]   cr0;

    // Instruction source / observer side
    modport master (
        output instruction, in_valid, hold, dbg_addr,
        input  in_ready, wb_valid, wb_reg, wb_data, illegal,
               retired_cnt, illegal_cnt, dbg_data, cr0
    );

    // Execution pipe side
    modport slave (
        input  instruction, in_valid, hold, dbg_addr,
        output in_ready, wb_valid, wb_reg, wb_data, illegal,
               retired_cnt, illegal_cnt, dbg_data, cr0
    );
endinterface

// File: rtl/ri_exec_pipe.sv
// ri_exec_pipe: two-stage uPOWER integer execution pipe.
// S1 holds decoded fields plus operands (with forwarding from S2); S2 runs
// the ALU and writes the register file. Optional macro CR0_EN enables cr0
// updates from Rc=1 instructions; without it cr0 is tied to zero.
module ri_exec_pipe #(
    parameter int unsigned N    = 64,
    parameter int unsigned NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    ri_exec_pipe_if.slave bus
);
    localparam int unsigned RW = $clog2(NREG);

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUBF = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4
    } alu_op_t;

    // Register index from a 5-bit instruction field, wrapped to NREG entries
    function automatic logic [RW-1:0] ridx(input logic [4:0] f);
        return RW'(32'(f) % NREG);
    endfunction

    // Instruction fields
    logic [5:0]  f_op;
    logic [4:0]  f_a;
    logic [4:0]  f_b;
    logic [4:0]  f_c;
    logic [9:0]  f_xo;
    logic [15:0] f_imm;

    assign f_op  = bus.instruction[31:26];
    assign f_a   = bus.instruction[25:21];
    assign f_b   = bus.instruction[20:16];
    assign f_c   = bus.instruction[15:11];
    assign f_xo  = bus.instruction[10:1];
    assign f_imm = bus.instruction[15:0];

    // Decode outputs
    logic          d_legal;
    alu_op_t       d_op;
    logic [RW-1:0] d_dest;
    logic [RW-1:0] d_ia;
    logic [RW-1:0] d_ib;
    logic          d_use_imm;
    logic          d_zero_a;
    logic [N-1:0]  d_imm;

    // Register file and pipeline state
    logic [N-1:0]  rf [NREG];
    logic          s1_valid;
    logic          s1_legal;
    alu_op_t       s1_op;
    logic [RW-1:0] s1_dest;
    logic [N-1:0]  s1_opa;
    logic [N-1:0]  s1_opb;

    logic          wb_valid_q;
    logic [4:0]    wb_reg_q;
    logic [N-1:0]  wb_data_q;
    logic          illegal_q;
    logic [31:0]   retired_q;
    logic [15:0]   illegal_cnt_q;

    logic          accept_c;
    logic          s2_wr_c;
    logic [N-1:0]  alu_res_c;
    logic [N-1:0]  opa_c;
    logic [N-1:0]  opb_c;

    // Accept only out of reset and when not frozen
    assign bus.in_ready = rst & ~bus.hold;
    assign accept_c     = bus.in_valid & bus.in_ready;
    assign s2_wr_c      = s1_valid & s1_legal;

    // Decode D-form and opcode-31 X-form encodings
    always_comb begin
        d_legal   = 1'b0;
        d_op      = ALU_ADD;
        d_dest    = ridx(f_a);
        d_ia      = ridx(f_b);
        d_ib      = ridx(f_c);
        d_use_imm = 1'b0;
        d_zero_a  = 1'b0;
        d_imm     = N'(f_imm);
        case (f_op)
            6'd14: begin
                d_legal   = 1'b1;
                d_op      = ALU_ADD;
                d_zero_a  = (f_b == 5'd0);
                d_use_imm = 1'b1;
                d_imm     = N'($signed(f_imm));
            end
            6'd24, 6'd26, 6'd28: begin
                d_legal   = 1'b1;
                d_op      = (f_op == 6'd24) ? ALU_OR :
                            (f_op == 6'd26) ? ALU_XOR : ALU_AND;
                d_dest    = ridx(f_b);
                d_ia      = ridx(f_a);
                d_use_imm = 1'b1;
            end
            6'd31: begin
                case (f_xo)
                    10'd266: begin
                        d_legal = 1'b1;
                        d_op    = ALU_ADD;
                    end
                    10'd40: begin
                        d_legal = 1'b1;
                        d_op    = ALU_SUBF;
                    end
                    10'd28, 10'd444, 10'd316: begin
                        d_legal = 1'b1;
                        d_op    = (f_xo == 10'd28)  ? ALU_AND :
                                  (f_xo == 10'd444) ? ALU_OR : ALU_XOR;
                        d_dest  = ridx(f_b);
                        d_ia    = ridx(f_a);
                    end
                    default: d_legal = 1'b0;
                endcase
            end
            default: d_legal = 1'b0;
        endcase
    end

    // Operand fetch with bypass of the value S2 writes at this same edge
    always_comb begin
        if (d_zero_a)
            opa_c = '0;
        else if (s2_wr_c && (s1_dest == d_ia))
            opa_c = alu_res_c;
        else
            opa_c = rf[d_ia];

        if (d_use_imm)
            opb_c = d_imm;
        else if (s2_wr_c && (s1_dest == d_ib))
            opb_c = alu_res_c;
        else
            opb_c = rf[d_ib];
    end

    // S2 ALU; arithmetic wraps modulo 2^N
    always_comb begin
        alu_res_c = '0;
        case (s1_op)
            ALU_ADD:  alu_res_c = s1_opa + s1_opb;
            ALU_SUBF: alu_res_c = s1_opb - s1_opa;
            ALU_AND:  alu_res_c = s1_opa & s1_opb;
            ALU_OR:   alu_res_c = s1_opa | s1_opb;
            ALU_XOR:  alu_res_c = s1_opa ^ s1_opb;
            default:  alu_res_c = '0;
        endcase
    end

    // S1 capture at accept; bubble otherwise; frozen under hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_legal <= 1'b0;
            s1_op    <= ALU_ADD;
            s1_dest  <= '0;
            s1_opa   <= '0;
            s1_opb   <= '0;
        end else if (!bus.hold) begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_legal <= d_legal;
                s1_op    <= d_op;
                s1_dest  <= d_dest;
                s1_opa   <= opa_c;
                s1_opb   <= opb_c;
            end
        end
    end

    // Register file write from S2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (!bus.hold && s2_wr_c) begin
            rf[s1_dest] <= alu_res_c;
        end
    end

    // Writeback status, illegal pulse and retire counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q    <= 1'b0;
            wb_reg_q      <= '0;
            wb_data_q     <= '0;
            illegal_q     <= 1'b0;
            retired_q     <= '0;
            illegal_cnt_q <= '0;
        end else if (bus.hold) begin
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            wb_valid_q <= s2_wr_c;
            illegal_q  <= s1_valid & ~s1_legal;
            if (s2_wr_c) begin
                wb_reg_q  <= 5'(s1_dest);
                wb_data_q <= alu_res_c;
                retired_q <= retired_q + 32'd1;
            end
            if (s1_valid && !s1_legal && (illegal_cnt_q != 16'hFFFF))
                illegal_cnt_q <= illegal_cnt_q + 16'd1;
        end
    end

`ifdef CR0_EN
    logic       d_rc;
    logic       s1_rc;
    logic [2:0] cr0_q;

    // andi. always records; X-form records when Rc is set
    assign d_rc = (f_op == 6'd28) || ((f_op == 6'd31) && bus.instruction[0]);

    // Rc flag travels with the instruction through S1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            s1_rc <= 1'b0;
        else if (!bus.hold && accept_c)
            s1_rc <= d_rc;
    end

    // cr0 = {LT, GT, EQ} of the signed result at its write edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cr0_q <= 3'b000;
        else if (!bus.hold && s2_wr_c && s1_rc)
            cr0_q <= {alu_res_c[N-1],
                      ~alu_res_c[N-1] & (alu_res_c != '0),
                      (alu_res_c == '0)};
    end

    assign bus.cr0 = cr0_q;
`else
    assign bus.cr0 = 3'b000;
`endif

    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_reg      = wb_reg_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.illegal     = illegal_q;
    assign bus.retired_cnt = retired_q;
    assign bus.illegal_cnt = illegal_cnt_q;
    assign bus.dbg_data    = rf[ridx(bus.dbg_addr)];
endmodule
